mem_dp_be_init: RTL

Parametrised dual-port memory for FIFO and buffer datapaths. One write port with per-lane byte enables and one read port with a registered read of configurable latency and a valid strobe. A hardware init sequencer clears every location after reset. Read-during-write on the same address follows a selectable collision mode.

---
 rtl/mem_dp_be_init.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/mem_dp_be_init.sv
// Dual-port memory with per-lane byte enables, a post-reset init sweep that writes INIT_VAL
// everywhere, and a registered read of 1 or 2 cycles latency with selectable read-during-write.

module mem_dp_be_lane #(
  parameter int BW       = 8,
  parameter int AW       = 4,
  parameter int RDW_MODE = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [BW-1:0] wd,
  input  logic          re,
  input  logic [AW-1:0] ra,
  input  logic [BW-1:0] rq_unused_tieoff,
  output logic [BW-1:0] rq
);
  logic [BW-1:0] m [2**AW];
  logic          fwd;

  // Write-through only when this lane is actually being written at the read address.
  assign fwd = (RDW_MODE != 0) && we && (wa == ra);

  always_ff @(posedge clk)
    if (we) m[wa] <= wd;

  always_ff @(posedge clk)
    if (rst)     rq <= '0;
    else if (re) rq <= fwd ? wd : m[ra];

  logic unused_ok;
  assign unused_ok = &{1'b0, rq_unused_tieoff};
endmodule

module mem_dp_be_init #(
  parameter int            DW       = 16,
  parameter int            AW       = 4,
  parameter int            BW       = 8,
  parameter int            RD_LAT   = 1,
  parameter int            RDW_MODE = 0,
  parameter logic [DW-1:0] INIT_VAL = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr,
  input  logic [DW/BW-1:0]    be,
  input  logic [AW-1:0]       wa,
  input  logic [DW-1:0]       din,
  input  logic                rd,
  input  logic [AW-1:0]       ra,
  output logic [DW-1:0]       dout,
  output logic                dout_vld,
  output logic                init_busy
);
  localparam int NB = DW / BW;

  localparam logic [0:0] S_INIT = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  typedef struct packed {
    logic          we;
    logic [NB-1:0] be;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wreq_t;

  generate
    if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
      $fatal(1, "mem_dp_be_init: RD_LAT must be 1 or 2");
    end
    if (DW % BW != 0) begin : g_bad_bw
      $fatal(1, "mem_dp_be_init: DW must be a multiple of BW");
    end
  endgenerate

  logic [0:0]            state;
  logic [AW-1:0]         cnt;
  wreq_t                 wq;
  logic                  rd_ok;
  logic [NB-1:0][BW-1:0] rq;
  logic [RD_LAT:1]       vld_pipe;

  always_ff @(posedge clk)
    if (rst) begin
      state <= S_INIT;
      cnt   <= '0;
    end else if (state == S_INIT) begin
      // Counter parks at MD-1; the last init write and the switch to RUN share an edge.
      if (&cnt) state <= S_RUN;
      else      cnt   <= cnt + AW'(1);
    end

  assign init_busy = (state == S_INIT);
  assign rd_ok     = rd && (state == S_RUN) && !rst;

  always_comb begin
    wq = '0;
    if (!rst) begin
      if (state == S_INIT) begin
        wq.we = 1'b1;
        wq.be = '1;
        wq.a  = cnt;
        wq.d  = INIT_VAL;
      end else begin
        wq.we = wr;
        wq.be = be;
        wq.a  = wa;
        wq.d  = din;
      end
    end
  end

  genvar i;
  generate
    for (i = 0; i < NB; i++) begin : g_lane
      mem_dp_be_lane #(.BW(BW), .AW(AW), .RDW_MODE(RDW_MODE)) u_lane (
        .clk              (clk),
        .rst              (rst),
        .we               (wq.we & wq.be[i]),
        .wa               (wq.a),
        .wd               (wq.d[i*BW +: BW]),
        .re               (rd_ok),
        .ra               (ra),
        .rq_unused_tieoff ('0),
        .rq               (rq[i])
      );
    end
  endgenerate

  always_ff @(posedge clk)
    if (rst) vld_pipe <= '0;
    else     vld_pipe <= RD_LAT'({vld_pipe, rd_ok});

  assign dout_vld = vld_pipe[RD_LAT];

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic [DW-1:0] dq2;
      always_ff @(posedge clk)
        if (rst)              dq2 <= '0;
        else if (vld_pipe[1]) dq2 <= rq;
      assign dout = dq2;
    end else begin : g_lat1
      assign dout = rq;
    end
  endgenerate
endmodule
